// File: rtl/feature_fifo_bank_pkg.sv
// Shared defaults and width helpers for the feature FIFO bank.
// The optional per-lane level output is enabled by FEATURE_FIFO_BANK_STATS_EN.
package feature_fifo_bank_pkg;

  localparam int DATA_W_DEF = 256;
  localparam int LANES_DEF  = 4;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/feature_fifo_bank_lane.sv
// One first-word-fall-through FIFO lane with full/empty flags and sticky overflow.
// With FEATURE_FIFO_BANK_STATS_EN defined the lane also exports its occupancy count.
module feature_fifo_lane
  import feature_fifo_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_push,
  input  logic              i_rd_ready,
  input  logic              i_clr_err,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow
`ifdef FEATURE_FIFO_BANK_STATS_EN
  ,
  output logic [cnt_w(DEPTH)-1:0] o_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;

  logic w_push;
  logic w_pop;
  logic w_drop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_valid = !o_empty;

  // A full lane still accepts a write when the head leaves on the same edge.
  assign w_pop  = o_valid && i_rd_ready;
  assign w_push = i_push && (!o_full || w_pop);
  assign w_drop = i_push && o_full && !w_pop;

  assign o_data     = o_empty ? '0 : r_mem[r_rptr];
  assign o_overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A drop on the clearing edge must survive the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_clr_err) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef FEATURE_FIFO_BANK_STATS_EN
  assign o_count = r_count;
`endif

endmodule

// File: rtl/feature_fifo_bank.sv
// Bank of independent FWFT lane FIFOs sharing one write data bus.
// Define FEATURE_FIFO_BANK_STATS_EN to add the per-lane o_level output.
module feature_fifo_bank
  import feature_fifo_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int LANES  = LANES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       i_feature_fifo,
  input  logic [LANES-1:0]        i_feature_fifo_valid,
  input  logic [LANES-1:0]        i_rd_ready,
  input  logic                    i_clr_err,
  output logic [LANES*DATA_W-1:0] o_feature,
  output logic [LANES-1:0]        o_feature_valid,
  output logic [LANES-1:0]        o_full,
  output logic [LANES-1:0]        o_empty,
  output logic [LANES-1:0]        o_overflow
`ifdef FEATURE_FIFO_BANK_STATS_EN
  ,
  output logic [LANES*cnt_w(DEPTH)-1:0] o_level
`endif
);

  localparam int CW = cnt_w(DEPTH);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
`ifdef FEATURE_FIFO_BANK_STATS_EN
    logic [CW-1:0] w_count;
    assign o_level[k*CW +: CW] = w_count;
`endif

    feature_fifo_lane #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .i_data     (i_feature_fifo),
      .i_push     (i_feature_fifo_valid[k]),
      .i_rd_ready (i_rd_ready[k]),
      .i_clr_err  (i_clr_err),
      .o_data     (o_feature[k*DATA_W +: DATA_W]),
      .o_valid    (o_feature_valid[k]),
      .o_full     (o_full[k]),
      .o_empty    (o_empty[k]),
      .o_overflow (o_overflow[k])
`ifdef FEATURE_FIFO_BANK_STATS_EN
      ,
      .o_count    (w_count)
`endif
    );
  end

endmodule

// File: tb/tb_feature_fifo_bank.sv
// Directed self-checking bench for feature_fifo_bank (DEPTH=16, DATA_W=256, LANES=4).
// Level checks are compiled in when FEATURE_FIFO_BANK_STATS_EN is defined.
module tb_feature_fifo_bank;

  localparam int DW = 256;
  localparam int DP = 16;
  localparam int LN = 4;
  localparam int CW = 5;

  logic             clk;
  logic             rst;
  logic [DW-1:0]    i_feature_fifo;
  logic [LN-1:0]    i_feature_fifo_valid;
  logic [LN-1:0]    i_rd_ready;
  logic             i_clr_err;
  logic [LN*DW-1:0] o_feature;
  logic [LN-1:0]    o_feature_valid;
  logic [LN-1:0]    o_full;
  logic [LN-1:0]    o_empty;
  logic [LN-1:0]    o_overflow;
`ifdef FEATURE_FIFO_BANK_STATS_EN
  logic [LN*CW-1:0] o_level;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  feature_fifo_bank #(.DATA_W(DW), .DEPTH(DP), .LANES(LN)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_feature_fifo       (i_feature_fifo),
    .i_feature_fifo_valid (i_feature_fifo_valid),
    .i_rd_ready           (i_rd_ready),
    .i_clr_err            (i_clr_err),
    .o_feature            (o_feature),
    .o_feature_valid      (o_feature_valid),
    .o_full               (o_full),
    .o_empty              (o_empty),
    .o_overflow           (o_overflow)
`ifdef FEATURE_FIFO_BANK_STATS_EN
    ,
    .o_level              (o_level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] lane_data(input int k);
    return o_feature[k*DW +: DW];
  endfunction

`ifdef FEATURE_FIFO_BANK_STATS_EN
  function automatic logic [CW-1:0] lane_level(input int k);
    return o_level[k*CW +: CW];
  endfunction
`endif

  task automatic test_reset();
    rst = 1'b1;
    i_feature_fifo = '0;
    i_feature_fifo_valid = '0;
    i_rd_ready = '0;
    i_clr_err = 1'b0;
    tick();
    tick();
    chk_cnt++; if (o_empty !== 4'b1111) $display("FAIL reset_empty: got %b exp 1111", o_empty); else pass_cnt++;
    chk_cnt++; if (o_full !== 4'b0000) $display("FAIL reset_full: got %b exp 0000", o_full); else pass_cnt++;
    chk_cnt++; if (o_feature_valid !== 4'b0000) $display("FAIL reset_valid: got %b exp 0000", o_feature_valid); else pass_cnt++;
    chk_cnt++; if (o_overflow !== 4'b0000) $display("FAIL reset_overflow: got %b exp 0000", o_overflow); else pass_cnt++;
    chk_cnt++; if (o_feature !== '0) $display("FAIL reset_data: got nonzero exp zero"); else pass_cnt++;
`ifdef FEATURE_FIFO_BANK_STATS_EN
    chk_cnt++; if (o_level !== '0) $display("FAIL reset_level: got %h exp 0", o_level); else pass_cnt++;
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    logic [DW-1:0] exp_d;
    exp_d = {8{32'hA5A5_A5A5}};
    i_feature_fifo = exp_d;
    i_feature_fifo_valid = 4'b0001;
    tick();
    i_feature_fifo_valid = 4'b0000;
    chk_cnt++; if (o_feature_valid !== 4'b0001) $display("FAIL single_valid: got %b exp 0001", o_feature_valid); else pass_cnt++;
    chk_cnt++; if (lane_data(0) !== exp_d) $display("FAIL single_data: got %h exp %h", lane_data(0), exp_d); else pass_cnt++;
    chk_cnt++; if (o_empty !== 4'b1110) $display("FAIL single_empty: got %b exp 1110", o_empty); else pass_cnt++;
`ifdef FEATURE_FIFO_BANK_STATS_EN
    chk_cnt++; if (lane_level(0) !== 5'd1) $display("FAIL single_level: got %0d exp 1", lane_level(0)); else pass_cnt++;
`endif
    i_rd_ready = 4'b0001;
    tick();
    i_rd_ready = 4'b0000;
    chk_cnt++; if (o_empty !== 4'b1111) $display("FAIL single_drain_empty: got %b exp 1111", o_empty); else pass_cnt++;
    chk_cnt++; if (lane_data(0) !== '0) $display("FAIL single_drain_zero: got %h exp 0", lane_data(0)); else pass_cnt++;
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 16; k++) begin
      i_feature_fifo = DW'(k);
      i_feature_fifo_valid = 4'b0100;
      tick();
    end
    chk_cnt++; if (o_full !== 4'b0100) $display("FAIL ovf_full16: got %b exp 0100", o_full); else pass_cnt++;
    chk_cnt++; if (o_overflow !== 4'b0000) $display("FAIL ovf_none_yet: got %b exp 0000", o_overflow); else pass_cnt++;
    i_feature_fifo = DW'(17);
    tick();
    i_feature_fifo_valid = 4'b0000;
    chk_cnt++; if (o_overflow !== 4'b0100) $display("FAIL ovf_set: got %b exp 0100", o_overflow); else pass_cnt++;
    chk_cnt++; if (o_full !== 4'b0100) $display("FAIL ovf_still_full: got %b exp 0100", o_full); else pass_cnt++;
`ifdef FEATURE_FIFO_BANK_STATS_EN
    chk_cnt++; if (lane_level(2) !== 5'd16) $display("FAIL ovf_level: got %0d exp 16", lane_level(2)); else pass_cnt++;
`endif
    i_rd_ready = 4'b0100;
    for (int k = 1; k <= 16; k++) begin
      chk_cnt++; if (lane_data(2) !== DW'(k)) $display("FAIL ovf_drain_%0d: got %h exp %h", k, lane_data(2), DW'(k)); else pass_cnt++;
      tick();
    end
    i_rd_ready = 4'b0000;
    chk_cnt++; if (o_empty !== 4'b1111) $display("FAIL ovf_no_17th: got %b exp 1111", o_empty); else pass_cnt++;
    chk_cnt++; if (o_overflow !== 4'b0100) $display("FAIL ovf_sticky: got %b exp 0100", o_overflow); else pass_cnt++;
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    chk_cnt++; if (o_overflow !== 4'b0000) $display("FAIL ovf_clear: got %b exp 0000", o_overflow); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_d;
    for (int k = 1; k <= 16; k++) begin
      i_feature_fifo = DW'(32'h100 + k);
      i_feature_fifo_valid = 4'b0010;
      exp_q.push_back(DW'(32'h100 + k));
      tick();
    end
    chk_cnt++; if (o_full !== 4'b0010) $display("FAIL pp_full: got %b exp 0010", o_full); else pass_cnt++;
    i_feature_fifo = DW'(32'h1FF);
    i_rd_ready = 4'b0010;
    void'(exp_q.pop_front());
    exp_q.push_back(DW'(32'h1FF));
    tick();
    i_feature_fifo_valid = 4'b0000;
    i_rd_ready = 4'b0000;
    chk_cnt++; if (o_overflow !== 4'b0000) $display("FAIL pp_no_overflow: got %b exp 0000", o_overflow); else pass_cnt++;
    chk_cnt++; if (o_full !== 4'b0010) $display("FAIL pp_still_full: got %b exp 0010", o_full); else pass_cnt++;
`ifdef FEATURE_FIFO_BANK_STATS_EN
    chk_cnt++; if (lane_level(1) !== 5'd16) $display("FAIL pp_level: got %0d exp 16", lane_level(1)); else pass_cnt++;
`endif
    i_rd_ready = 4'b0010;
    while (exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      chk_cnt++; if (lane_data(1) !== exp_d) $display("FAIL pp_drain: got %h exp %h", lane_data(1), exp_d); else pass_cnt++;
      tick();
    end
    i_rd_ready = 4'b0000;
    chk_cnt++; if (o_empty !== 4'b1111) $display("FAIL pp_empty: got %b exp 1111", o_empty); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int rcv [LN];
    logic saw_full;
    for (int m = 0; m < LN; m++) rcv[m] = 0;
    saw_full = 1'b0;
    i_rd_ready = 4'b1111;
    for (int r = 0; r < 20; r++) begin
      for (int l = 0; l < LN; l++) begin
        i_feature_fifo = DW'(l * 256 + r);
        i_feature_fifo_valid = LN'(1 << l);
        tick();
        if (o_full !== 4'b0000) saw_full = 1'b1;
        for (int m = 0; m < LN; m++) begin
          if (o_feature_valid[m]) begin
            chk_cnt++;
            if (lane_data(m) !== DW'(m * 256 + rcv[m]))
              $display("FAIL rr_lane%0d_word%0d: got %h exp %h", m, rcv[m], lane_data(m), DW'(m * 256 + rcv[m]));
            else pass_cnt++;
            rcv[m]++;
          end
        end
      end
    end
    i_feature_fifo_valid = 4'b0000;
    tick();
    i_rd_ready = 4'b0000;
    for (int m = 0; m < LN; m++) begin
      chk_cnt++; if (rcv[m] != 20) $display("FAIL rr_count_lane%0d: got %0d exp 20", m, rcv[m]); else pass_cnt++;
    end
    chk_cnt++; if (saw_full !== 1'b0) $display("FAIL rr_never_full: got %b exp 0", saw_full); else pass_cnt++;
    chk_cnt++; if (o_empty !== 4'b1111) $display("FAIL rr_empty: got %b exp 1111", o_empty); else pass_cnt++;
  endtask

  task automatic test_clr_vs_overflow();
    for (int k = 1; k <= 16; k++) begin
      i_feature_fifo = DW'(32'h200 + k);
      i_feature_fifo_valid = 4'b0101;
      tick();
    end
    chk_cnt++; if (o_full !== 4'b0101) $display("FAIL clr_multihot_full: got %b exp 0101", o_full); else pass_cnt++;
    i_feature_fifo = DW'(32'h2EE);
    i_feature_fifo_valid = 4'b0100;
    tick();
    chk_cnt++; if (o_overflow !== 4'b0100) $display("FAIL clr_pre_overflow: got %b exp 0100", o_overflow); else pass_cnt++;
    i_feature_fifo = DW'(32'h2FF);
    i_feature_fifo_valid = 4'b0001;
    i_clr_err = 1'b1;
    tick();
    i_feature_fifo_valid = 4'b0000;
    i_clr_err = 1'b0;
    chk_cnt++; if (o_overflow !== 4'b0001) $display("FAIL clr_overflow_wins: got %b exp 0001", o_overflow); else pass_cnt++;
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    chk_cnt++; if (o_overflow !== 4'b0000) $display("FAIL clr_plain: got %b exp 0000", o_overflow); else pass_cnt++;
    i_rd_ready = 4'b0101;
    for (int k = 1; k <= 16; k++) begin
`ifdef FEATURE_FIFO_BANK_STATS_EN
      chk_cnt++; if (lane_level(0) !== CW'(17 - k)) $display("FAIL clr_level_%0d: got %0d exp %0d", k, lane_level(0), 17 - k); else pass_cnt++;
`endif
      chk_cnt++; if (lane_data(0) !== DW'(32'h200 + k)) $display("FAIL clr_lane0_%0d: got %h exp %h", k, lane_data(0), DW'(32'h200 + k)); else pass_cnt++;
      chk_cnt++; if (lane_data(2) !== DW'(32'h200 + k)) $display("FAIL clr_lane2_%0d: got %h exp %h", k, lane_data(2), DW'(32'h200 + k)); else pass_cnt++;
      tick();
    end
    i_rd_ready = 4'b0000;
    chk_cnt++; if (o_empty !== 4'b1111) $display("FAIL clr_empty: got %b exp 1111", o_empty); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 5; k++) begin
      i_feature_fifo = DW'(32'h300 + k);
      i_feature_fifo_valid = 4'b1000;
      tick();
    end
    i_feature_fifo_valid = 4'b0000;
    chk_cnt++; if (o_empty !== 4'b0111) $display("FAIL rmid_loaded: got %b exp 0111", o_empty); else pass_cnt++;
`ifdef FEATURE_FIFO_BANK_STATS_EN
    chk_cnt++; if (lane_level(3) !== 5'd5) $display("FAIL rmid_level5: got %0d exp 5", lane_level(3)); else pass_cnt++;
`endif
    #2;
    rst = 1'b1;
    #1;
    chk_cnt++; if (o_empty !== 4'b1111) $display("FAIL rmid_async_empty: got %b exp 1111", o_empty); else pass_cnt++;
    chk_cnt++; if (lane_data(3) !== '0) $display("FAIL rmid_zero: got %h exp 0", lane_data(3)); else pass_cnt++;
    chk_cnt++; if (o_feature_valid !== 4'b0000) $display("FAIL rmid_valid: got %b exp 0000", o_feature_valid); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    i_feature_fifo = DW'(32'hBEEF);
    i_feature_fifo_valid = 4'b1000;
    tick();
    i_feature_fifo_valid = 4'b0000;
    chk_cnt++; if (o_feature_valid !== 4'b1000) $display("FAIL rmid_repush_valid: got %b exp 1000", o_feature_valid); else pass_cnt++;
    chk_cnt++; if (lane_data(3) !== DW'(32'hBEEF)) $display("FAIL rmid_repush_data: got %h exp %h", lane_data(3), DW'(32'hBEEF)); else pass_cnt++;
`ifdef FEATURE_FIFO_BANK_STATS_EN
    chk_cnt++; if (lane_level(3) !== 5'd1) $display("FAIL rmid_level1: got %0d exp 1", lane_level(3)); else pass_cnt++;
`endif
    i_rd_ready = 4'b1000;
    tick();
    i_rd_ready = 4'b0000;
    chk_cnt++; if (o_empty !== 4'b1111) $display("FAIL rmid_single_word: got %b exp 1111", o_empty); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_overflow();
    test_full_push_pop();
    test_round_robin();
    test_clr_vs_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/feature_fifo_bank.md
FEATURE_FIFO_BANK -- requirements
Module: feature_fifo_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 256, meaning width of one feature word.
REQ-002 SHALL have parameter DEPTH, default 16, meaning entries per lane FIFO; legal values are powers of two, 4 to 256.
REQ-003 SHALL have parameter LANES, default 4, meaning number of lane FIFOs (fixed 4 in this release).
REQ-004 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port i_feature_fifo  input  DATA_W  write data, shared by all lanes.
REQ-007 SHALL have port i_feature_fifo_valid  input  LANES  per-lane write strobe, normally one-hot or zero.
REQ-008 SHALL have port i_rd_ready  input  LANES  per-lane consumer ready.
REQ-009 SHALL have port o_feature  output  LANES*DATA_W  per-lane head word; lane k occupies bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port o_feature_valid  output  LANES  per-lane head-valid.
REQ-011 SHALL have port o_full  output  LANES  per-lane full flag.
REQ-012 SHALL have port o_empty  output  LANES  per-lane empty flag.
REQ-013 SHALL have port o_overflow  output  LANES  per-lane sticky overflow error.
REQ-014 SHALL have port i_clr_err  input  1  synchronous clear of o_overflow.

Function
REQ-015 Lane k SHALL push i_feature_fifo on any edge where i_feature_fifo_valid[k]=1 and lane k is not full, or is full with a same-cycle pop.
REQ-016 Multi-hot strobes SHALL write the same word into every strobed lane; this is not an error.
REQ-017 A push into a full lane without a same-cycle pop SHALL be dropped and SHALL set o_overflow[k] on that edge; stored data SHALL be unchanged.
REQ-018 Read side SHALL be first-word-fall-through: o_feature_valid[k] = !o_empty[k], and the lane k slice of o_feature presents the oldest entry.
REQ-019 Lane k SHALL pop on an edge where o_feature_valid[k]=1 and i_rd_ready[k]=1.
REQ-020 A word pushed at edge N SHALL be visible with o_feature_valid high after edge N (1-cycle write-to-read latency).
REQ-021 The lane k slice of o_feature SHALL be driven to all-zero while lane k is empty.
REQ-022 Each lane SHALL keep write/read pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy count of log2(DEPTH)+1 bits.
REQ-023 o_empty[k] SHALL be high exactly when count=0; o_full[k] SHALL be high exactly when count=DEPTH; both SHALL come from registered state.
REQ-024 A simultaneous push and pop SHALL leave the count unchanged and advance both pointers.
REQ-025 i_clr_err=1 SHALL clear all o_overflow bits on that edge; an overflow event in the same cycle SHALL win, leaving that bit set.
REQ-026 Lanes SHALL be fully independent; no lane's state SHALL affect another lane.

Reset
REQ-027 rst high SHALL asynchronously clear pointers and counts, and SHALL drive o_empty to all ones and o_full, o_feature_valid and o_overflow to zero.
REQ-028 Storage RAM SHALL NOT be reset; o_feature is all-zero during reset through REQ-021.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered words; the first push after release SHALL land in entry 0.

Configuration
REQ-030 With FEATURE_FIFO_BANK_STATS_EN defined, the block SHALL add output o_level, LANES*(log2(DEPTH)+1) bits, giving each lane's registered count; o_level SHALL reset to 0.
REQ-031 Without FEATURE_FIFO_BANK_STATS_EN, the o_level port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 A shared package SHALL hold the LANES and DATA_W defaults and a function computing the count width from DEPTH.
REQ-033 Each lane SHALL be one instance of sub-module feature_fifo_lane (single FWFT FIFO with full/empty/overflow), generated LANES times.

Verification
REQ-034 Reset, then one strobe 0001 with data 0xA5..A5 and i_rd_ready=0: next cycle o_feature_valid=0001 and lane 0 reads 0xA5..A5; o_empty=1110.
REQ-035 Write 16 words to lane 2 with DEPTH=16 and no reads, then a 17th word: o_full[2]=1 and o_overflow[2]=1; draining returns words 1..16 in order, with no 17th word.
REQ-036 Lane 1 full with push and pop in the same cycle: o_overflow[1] stays 0, count stays 16, and the new word appears last when drained.
REQ-037 Round-robin strobes 0001, 0010, 0100, 1000 repeated 20 times with all i_rd_ready=1: every lane outputs its 20 words in order, and the lanes never go full.
REQ-038 rst pulse while lane 3 holds 5 words: o_empty[3]=1 immediately and the lane 3 slice of o_feature=0; a subsequent push reads back correctly.
REQ-039 i_clr_err in the same cycle as an overflow on lane 0 keeps o_overflow[0]=1 and clears the other lanes' bits; STATS_EN build: o_level matches the count at every step.
